// File: rtl/fetch_if_stage_pkg.sv
// ---------------------------------------------------------------------------
// fetch_if_stage_pkg
// Shared constants and types for the MIPS fetch stage and its IF/ID register:
//   RESET_PC_DEFAULT - default start of text segment
//   NOP_WORD         - instruction word used for bubbles
//   SEL_*            - next-PC select encoding
//   ifid_t           - IF/ID pipeline register payload
//   br_offset()      - sign-extend and word-shift a 16-bit branch immediate
// ---------------------------------------------------------------------------
package fetch_if_stage_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [XLEN-1:0] NOP_WORD         = 32'h0000_0000;

  localparam logic [1:0] SEL_PC4 = 2'd0;
  localparam logic [1:0] SEL_BR  = 2'd1;
  localparam logic [1:0] SEL_J   = 2'd2;
  localparam logic [1:0] SEL_JR  = 2'd3;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc8;
    logic            valid;
  } ifid_t;

  // Byte offset of a branch: signext(imm16) << 2.
  function automatic logic [XLEN-1:0] br_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_if_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_if_stage_if
// Bundle of hazard/redirect inputs, IM fetch bus and IF/ID outputs.
//   master : pipeline side (hazard unit, decode, IM) driving the fetch stage
//   slave  : the fetch stage itself
// Signals:
//   StallF, BranchD, JumpD, JumpRegD, JrTargetD - stall and redirect controls
//   InstrF / PCF                                - instruction memory port
//   InstrD, PCD, PC8D, ValidD                   - IF/ID contents
//   AddrErrF                                    - fetch address error (comb)
// ---------------------------------------------------------------------------
interface fetch_if_stage_if;

  logic        StallF;
  logic        BranchD;
  logic        JumpD;
  logic        JumpRegD;
  logic [31:0] JrTargetD;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PC8D;
  logic        ValidD;
  logic        AddrErrF;

  modport master (
    output StallF, BranchD, JumpD, JumpRegD, JrTargetD, InstrF,
    input  PCF, InstrD, PCD, PC8D, ValidD, AddrErrF
  );

  modport slave (
    input  StallF, BranchD, JumpD, JumpRegD, JrTargetD, InstrF,
    output PCF, InstrD, PCD, PC8D, ValidD, AddrErrF
  );

endinterface

// File: rtl/fetch_if_stage_if_id_reg.sv
// ---------------------------------------------------------------------------
// fetch_if_stage_if_id_reg
// IF/ID pipeline register with stall, flush and async active-high reset.
// Ports:
//   clk, reset     - clock, async active-high reset
//   i_stall        - hold all contents (wins over flush)
//   i_flush        - load a bubble (nop, PC 0, invalid)
//   i_addr_err     - fetch address bad: latch nop and mark invalid
//   i_instr, i_pc  - fetched word and its address
//   o_instr, o_pc, o_pc8, o_valid - registered IF/ID contents
// ---------------------------------------------------------------------------
module fetch_if_stage_if_id_reg
  import fetch_if_stage_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            i_stall,
  input  logic            i_flush,
  input  logic            i_addr_err,
  input  logic [XLEN-1:0] i_instr,
  input  logic [XLEN-1:0] i_pc,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc8,
  output logic            o_valid
);

  ifid_t r_ifid;

  // Link value is registered alongside PCD so it stays a clean flop output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ifid.instr <= NOP_WORD;
      r_ifid.pc    <= '0;
      r_ifid.pc8   <= 32'd8;
      r_ifid.valid <= 1'b0;
    end else if (!i_stall) begin
      if (i_flush) begin
        r_ifid.instr <= NOP_WORD;
        r_ifid.pc    <= '0;
        r_ifid.pc8   <= 32'd8;
        r_ifid.valid <= 1'b0;
      end else begin
        r_ifid.instr <= i_addr_err ? NOP_WORD : i_instr;
        r_ifid.pc    <= i_pc;
        r_ifid.pc8   <= i_pc + 32'd8;
        r_ifid.valid <= !i_addr_err;
      end
    end
  end

  assign o_instr = r_ifid.instr;
  assign o_pc    = r_ifid.pc;
  assign o_pc8   = r_ifid.pc8;
  assign o_valid = r_ifid.valid;

endmodule

// File: rtl/fetch_if_stage.sv
// ---------------------------------------------------------------------------
// fetch_if_stage
// Instruction-fetch stage of the 5-stage MIPS core: PC register, next-PC
// selection from decode-stage redirects, fetch address check, IF/ID register.
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous active-high reset
//   bus    - fetch_if_stage_if.slave (stall/redirect in, IM port, IF/ID out)
// Parameters:
//   RESET_PC - PC after reset, base of instruction memory
//   IM_WORDS - instruction memory depth in words
// Configuration:
//   FETCH_DELAY_SLOT_EN - defined: branch delay slot is kept (no flush);
//                         undefined: IF/ID is flushed on any redirect.
// ---------------------------------------------------------------------------
module fetch_if_stage
  import fetch_if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned IM_WORDS = 1024
) (
  input  logic             clk,
  input  logic             reset,
  fetch_if_stage_if.slave  bus
);

  localparam logic [XLEN-1:0] PC_LAST = RESET_PC + 32'(IM_WORDS * 4) - 32'd4;

  logic [XLEN-1:0] r_pcf;
  logic [XLEN-1:0] w_pc4;
  logic [XLEN-1:0] w_pcd4;
  logic [XLEN-1:0] w_br_tgt;
  logic [XLEN-1:0] w_j_tgt;
  logic [XLEN-1:0] w_next_pc;
  logic [1:0]      w_sel;
  logic            w_addr_err;
  logic            w_flush;
  logic [XLEN-1:0] w_instrd;
  logic [XLEN-1:0] w_pcd;
  logic [XLEN-1:0] w_pc8d;
  logic            w_validd;

  // Redirect targets come from the instruction currently held in IF/ID.
  assign w_pc4    = r_pcf + 32'd4;
  assign w_pcd4   = w_pcd + 32'd4;
  assign w_br_tgt = w_pcd4 + br_offset(w_instrd[15:0]);
  assign w_j_tgt  = {w_pcd4[31:28], w_instrd[25:0], 2'b00};

  // Redirect priority: jr/jalr, then j/jal, then taken branch.
  always_comb begin
    w_sel = SEL_PC4;
    if (bus.JumpRegD) begin
      w_sel = SEL_JR;
    end else if (bus.JumpD) begin
      w_sel = SEL_J;
    end else if (bus.BranchD) begin
      w_sel = SEL_BR;
    end
  end

  always_comb begin
    w_next_pc = w_pc4;
    case (w_sel)
      SEL_JR:  w_next_pc = bus.JrTargetD;
      SEL_J:   w_next_pc = w_j_tgt;
      SEL_BR:  w_next_pc = w_br_tgt;
      default: w_next_pc = w_pc4;
    endcase
  end

  // PC register; a stall also discards any redirect presented that cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pcf <= RESET_PC;
    end else if (!bus.StallF) begin
      r_pcf <= w_next_pc;
    end
  end

  // Misaligned or outside the instruction memory window.
  assign w_addr_err = (r_pcf[1:0] != 2'b00) || (r_pcf < RESET_PC) || (r_pcf > PC_LAST);

`ifdef FETCH_DELAY_SLOT_EN
  assign w_flush = 1'b0;
`else
  assign w_flush = bus.BranchD | bus.JumpD | bus.JumpRegD;
`endif

  fetch_if_stage_if_id_reg u_if_id_reg (
    .clk        (clk),
    .reset      (reset),
    .i_stall    (bus.StallF),
    .i_flush    (w_flush),
    .i_addr_err (w_addr_err),
    .i_instr    (bus.InstrF),
    .i_pc       (r_pcf),
    .o_instr    (w_instrd),
    .o_pc       (w_pcd),
    .o_pc8      (w_pc8d),
    .o_valid    (w_validd)
  );

  assign bus.PCF      = r_pcf;
  assign bus.InstrD   = w_instrd;
  assign bus.PCD      = w_pcd;
  assign bus.PC8D     = w_pc8d;
  assign bus.ValidD   = w_validd;
  assign bus.AddrErrF = w_addr_err;

endmodule

// File: tb/tb_fetch_if_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_if_stage
// Directed scenarios followed by randomized redirects/stalls/resets, all
// compared against a transaction-level model of the fetch stage.
// ---------------------------------------------------------------------------
module tb_fetch_if_stage;

  localparam logic [31:0] TB_BASE = 32'h0000_3000;
  localparam logic [31:0] TB_LAST = 32'h0000_3FFC;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fetch_if_stage_if ifb ();

  fetch_if_stage #(
    .RESET_PC (32'h0000_3000),
    .IM_WORDS (1024)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb)
  );

  // Instruction memory image
  logic [31:0] im [0:1023];

  function automatic bit bad_addr(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a < TB_BASE) || (a > TB_LAST);
  endfunction

  function automatic logic [31:0] im_word(input logic [31:0] a);
    if (bad_addr(a)) return 32'hDEAD_BEEF;
    return im[10'((a - TB_BASE) >> 2)];
  endfunction

  logic [9:0] w_im_idx;
  logic       w_im_hit;
  assign w_im_idx   = 10'((ifb.PCF - TB_BASE) >> 2);
  assign w_im_hit   = !bad_addr(ifb.PCF);
  assign ifb.InstrF = w_im_hit ? im[w_im_idx] : 32'hDEAD_BEEF;

  // Reference model state
  logic [31:0] m_pc, m_instrd, m_pcd;
  logic        m_validd;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_pc     = TB_BASE;
    m_instrd = 32'h0;
    m_pcd    = 32'h0;
    m_validd = 1'b0;
  endtask

  // One clock edge of the fetch stage, expressed as the architectural rules.
  task automatic m_edge(input bit st, input bit br, input bit j, input bit jr,
                        input logic [31:0] tgt);
    logic [31:0] nxt, link4;
    bit flush;
    if (st) return;
    link4 = m_pcd + 32'd4;
    if (jr)      nxt = tgt;
    else if (j)  nxt = {link4[31:28], m_instrd[25:0], 2'b00};
    else if (br) nxt = link4 + 32'($signed(m_instrd[15:0]) * 4);
    else         nxt = m_pc + 32'd4;
`ifdef FETCH_DELAY_SLOT_EN
    flush = 1'b0;
`else
    flush = br || j || jr;
`endif
    if (flush) begin
      m_instrd = 32'h0; m_pcd = 32'h0; m_validd = 1'b0;
    end else if (bad_addr(m_pc)) begin
      m_instrd = 32'h0; m_pcd = m_pc; m_validd = 1'b0;
    end else begin
      m_instrd = im_word(m_pc); m_pcd = m_pc; m_validd = 1'b1;
    end
    m_pc = nxt;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".PCF"},      ifb.PCF,            m_pc);
    chk({tag, ".InstrD"},   ifb.InstrD,         m_instrd);
    chk({tag, ".PCD"},      ifb.PCD,            m_pcd);
    chk({tag, ".PC8D"},     ifb.PC8D,           m_pcd + 32'd8);
    chk({tag, ".ValidD"},   32'(ifb.ValidD),    32'(m_validd));
    chk({tag, ".AddrErrF"}, 32'(ifb.AddrErrF),  32'(bad_addr(m_pc)));
  endtask

  // Drive one cycle of inputs, clock it, then compare a little after the edge.
  task automatic step(input string tag, input bit st, input bit br, input bit j,
                      input bit jr, input logic [31:0] tgt);
    ifb.StallF = st; ifb.BranchD = br; ifb.JumpD = j; ifb.JumpRegD = jr;
    ifb.JrTargetD = tgt;
    @(posedge clk);
    m_edge(st, br, j, jr, tgt);
    #1;
    check_all(tag);
  endtask

  // Reset pulse landing between clock edges (called just after an edge).
  task automatic mid_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    m_reset();
    check_all(tag);
    #2 reset = 1'b0;
  endtask

  initial begin
    int r;
    logic [31:0] tgt;
    bit st, br, j, jr;

    for (int k = 0; k < 1024; k++) begin
      if ($urandom_range(1, 0) == 1)
        im[k] = {6'h02, 26'(32'h0C00 + $urandom_range(1023, 0))};
      else
        im[k] = {16'h1000, 16'(int'($urandom_range(32, 0)) - 16)};
    end
    im[1] = 32'h1000_0003;   // branch +3 words at 0x3004
    im[2] = 32'h2402_0005;   // delay-slot word at 0x3008
    im[4] = 32'h0800_0C10;   // j 0x3040 at 0x3010

    ifb.StallF = 1'b0; ifb.BranchD = 1'b0; ifb.JumpD = 1'b0;
    ifb.JumpRegD = 1'b0; ifb.JrTargetD = 32'h0;
    @(posedge clk); #1;
    mid_reset("reset");
    chk("reset.pcf_const", ifb.PCF, 32'h3000);

    step("seq1", 0, 0, 0, 0, 0);
    chk("seq1.pcf_const", ifb.PCF, 32'h3004);
    chk("seq1.pcd_const", ifb.PCD, 32'h3000);
    step("seq2", 0, 0, 0, 0, 0);
    chk("seq2.pcd_const", ifb.PCD, 32'h3004);

    step("branch", 0, 1, 0, 0, 0);
    chk("branch.target", ifb.PCF, 32'h3014);
`ifdef FETCH_DELAY_SLOT_EN
    chk("branch.slot_instr", ifb.InstrD, 32'h2402_0005);
    chk("branch.slot_valid", 32'(ifb.ValidD), 32'd1);
`else
    chk("branch.flush_instr", ifb.InstrD, 32'h0);
    chk("branch.flush_valid", 32'(ifb.ValidD), 32'd0);
`endif

    step("jr3010", 0, 0, 0, 1, 32'h3010);
    step("fetch3010", 0, 0, 0, 0, 0);
    chk("jump.setup_pcd", ifb.PCD, 32'h3010);
    step("jump", 0, 0, 1, 0, 0);
    chk("jump.target", ifb.PCF, 32'h3040);
    step("jprio", 0, 0, 1, 1, 32'h3100);
    chk("jprio.target", ifb.PCF, 32'h3100);

    step("stall1", 1, 1, 0, 0, 0);
    chk("stall1.pcf_hold", ifb.PCF, 32'h3100);
    step("stall2", 1, 1, 0, 0, 0);
    chk("stall2.pcf_hold", ifb.PCF, 32'h3100);
    step("stall_rel", 0, 1, 0, 0, 0);

    step("aerr_mis", 0, 0, 0, 1, 32'h3102);
    chk("aerr_mis.pcf", ifb.PCF, 32'h3102);
    chk("aerr_mis.flag", 32'(ifb.AddrErrF), 32'd1);
    step("aerr_lat", 0, 0, 0, 0, 0);
    chk("aerr_lat.instr", ifb.InstrD, 32'h0);
    chk("aerr_lat.valid", 32'(ifb.ValidD), 32'd0);
    chk("aerr_lat.pcd", ifb.PCD, 32'h3102);
    step("aerr_hi", 0, 0, 0, 1, 32'h4000);
    chk("aerr_hi.flag", 32'(ifb.AddrErrF), 32'd1);
    step("edge_last", 0, 0, 0, 1, 32'h3FFC);
    chk("edge_last.flag", 32'(ifb.AddrErrF), 32'd0);
    step("edge_low", 0, 0, 0, 1, 32'h2FFC);
    chk("edge_low.flag", 32'(ifb.AddrErrF), 32'd1);

    step("jr3020", 0, 0, 0, 1, 32'h3020);
    step("pc8", 0, 0, 0, 0, 0);
    chk("pc8.pcd", ifb.PCD, 32'h3020);
    chk("pc8.link", ifb.PC8D, 32'h3028);

    step("wrap_set", 0, 0, 0, 1, 32'hFFFF_FFFC);
    step("wrap", 0, 0, 0, 0, 0);
    chk("wrap.pcf", ifb.PCF, 32'h0);
    chk("wrap.flag", 32'(ifb.AddrErrF), 32'd1);

    // Reset while a redirect and stall are pending: the redirect is lost.
    ifb.JumpRegD = 1'b1; ifb.JrTargetD = 32'h3500; ifb.StallF = 1'b1;
    mid_reset("rst_redir");
    step("post_rst", 0, 0, 0, 0, 0);
    chk("post_rst.pcf", ifb.PCF, 32'h3004);

    for (int n = 0; n < 1500; n++) begin
      st = ($urandom_range(99, 0) < 15);
      jr = ($urandom_range(99, 0) < 10);
      j  = ($urandom_range(99, 0) < 10);
      br = ($urandom_range(99, 0) < 15);
      r  = int'($urandom_range(9, 0));
      if (r < 8)       tgt = TB_BASE + 32'(4 * $urandom_range(1023, 0));
      else if (r == 8) tgt = TB_BASE + 32'($urandom_range(4095, 0));
      else             tgt = $urandom();
      step("rand", st, br, j, jr, tgt);
      if ($urandom_range(99, 0) == 0) mid_reset("rand_rst");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
